// File: rtl/uart_pkg.sv
// Shared definitions for the UART hex loader: parser state encoding and the
// ASCII byte values the parser reacts to.
package uart_pkg;

    // Parser state, also driven to the LEDs. ST_ERR is reserved; the error
    // condition is a sticky flag, not a state.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ADDR = 2'd2,
        ST_ERR  = 2'd3
    } parser_state_t;

    localparam logic [7:0] ASCII_AT   = 8'h40;
    localparam logic [7:0] ASCII_G_UP = 8'h47;
    localparam logic [7:0] ASCII_G_LO = 8'h67;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_SP   = 8'h20;

    // Word/address terminators: line feed, carriage return, space.
    function automatic logic is_terminator(input logic [7:0] b);
        return (b == ASCII_LF) || (b == ASCII_CR) || (b == ASCII_SP);
    endfunction

endpackage

// File: rtl/hex_nibble_decode.sv
// Combinational ASCII hex digit decoder; accepts 0-9, a-f and A-F.
module hex_nibble_decode (
    input  logic [7:0] byte_in,
    output logic       is_hex,
    output logic [3:0] nibble
);

    // Classify the byte and map it to its 4-bit value.
    always_comb begin
        is_hex = 1'b0;
        nibble = 4'd0;
        if (byte_in >= 8'h30 && byte_in <= 8'h39) begin
            is_hex = 1'b1;
            nibble = byte_in[3:0];
        end else if ((byte_in >= 8'h41 && byte_in <= 8'h46) ||
                     (byte_in >= 8'h61 && byte_in <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so add 9 to land on 10..15.
            is_hex = 1'b1;
            nibble = byte_in[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/uart_hex_loader.sv
// ASCII hex loader: turns the UART byte stream into memory writes and a go
// pulse for the mini-EDSAC store.
// Optional build macro UART_HEX_LOADER_ECHO_EN adds a byte echo port
// (tx_data/tx_valid/tx_ready).
module uart_hex_loader
    import uart_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int WORD_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_strobe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              go,
    output logic              error,
`ifdef UART_HEX_LOADER_ECHO_EN
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
`endif
    output logic [1:0]        state_out
);

    // The accumulator must hold either a full word or a full address.
    localparam int ACC_W = (ADDR_W > WORD_W) ? ADDR_W : WORD_W;

    parser_state_t     state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [ACC_W-1:0]  acc_reg, acc_next;
    logic              seen_reg, seen_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [WORD_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic              mem_we_reg, mem_we_next;
    logic              go_reg, go_next;
    logic              error_reg, error_next;

    logic              is_hex;
    logic [3:0]        nibble;

    hex_nibble_decode u_decode (
        .byte_in (rx_data),
        .is_hex  (is_hex),
        .nibble  (nibble)
    );

    // Parser state and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            acc_reg       <= '0;
            seen_reg      <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_we_reg    <= 1'b0;
            go_reg        <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            acc_reg       <= acc_next;
            seen_reg      <= seen_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_we_reg    <= mem_we_next;
            go_reg        <= go_next;
            error_reg     <= error_next;
        end
    end

    // Byte classification, next-state and registered output decisions.
    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        acc_next       = acc_reg;
        seen_next      = seen_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_we_next    = 1'b0;
        go_next        = 1'b0;
        error_next     = error_reg;

        if (rx_strobe) begin
            if (is_hex) begin
                // Shift in the new digit; older digits fall off the top.
                acc_next  = {acc_reg[ACC_W-5:0], nibble};
                seen_next = 1'b1;
                if (state_reg != ST_ADDR) begin
                    state_next = ST_DATA;
                end
            end else if (rx_data == ASCII_AT) begin
                acc_next   = '0;
                seen_next  = 1'b0;
                state_next = ST_ADDR;
            end else if (is_terminator(rx_data)) begin
                if (seen_reg && state_reg == ST_DATA) begin
                    mem_we_next    = 1'b1;
                    mem_addr_next  = addr_reg;
                    mem_wdata_next = acc_reg[WORD_W-1:0];
                    addr_next      = addr_reg + ADDR_W'(1);
                end else if (seen_reg && state_reg == ST_ADDR) begin
                    addr_next = acc_reg[ADDR_W-1:0];
                end
                acc_next   = '0;
                seen_next  = 1'b0;
                state_next = ST_IDLE;
            end else if (rx_data == ASCII_G_UP || rx_data == ASCII_G_LO) begin
                go_next    = 1'b1;
                acc_next   = '0;
                seen_next  = 1'b0;
                state_next = ST_IDLE;
            end else begin
                error_next = 1'b1;
                acc_next   = '0;
                seen_next  = 1'b0;
                state_next = ST_IDLE;
            end
        end
    end

    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_we    = mem_we_reg;
    assign go        = go_reg;
    assign error     = error_reg;
    assign state_out = state_reg;

`ifdef UART_HEX_LOADER_ECHO_EN
    logic [7:0] tx_data_reg;
    logic       tx_valid_reg;

    // Echo holding register: capture a byte only when the slot is empty;
    // bytes arriving while a previous echo is still pending are not echoed.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data_reg  <= 8'd0;
            tx_valid_reg <= 1'b0;
        end else if (tx_valid_reg && tx_ready) begin
            tx_valid_reg <= 1'b0;
        end else if (!tx_valid_reg && rx_strobe) begin
            tx_valid_reg <= 1'b1;
            tx_data_reg  <= rx_data;
        end
    end

    assign tx_data  = tx_data_reg;
    assign tx_valid = tx_valid_reg;
`endif

endmodule

// File: tb/tb_uart_hex_loader.sv
// Scoreboard bench for uart_hex_loader: stimulus pushes expected writes/go
// pulses into a queue, a monitor pops and compares each DUT output pulse.
module tb_uart_hex_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_strobe = 1'b0;
    logic [9:0]  mem_addr;
    logic [17:0] mem_wdata;
    logic        mem_we;
    logic        go;
    logic        error;
    logic [1:0]  state_out;
`ifdef UART_HEX_LOADER_ECHO_EN
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
`endif

    uart_hex_loader #(.ADDR_W(10), .WORD_W(18)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_strobe (rx_strobe),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .go        (go),
        .error     (error),
`ifdef UART_HEX_LOADER_ECHO_EN
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
`endif
        .state_out (state_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_go;
        logic [9:0]  addr;
        logic [17:0] data;
        int          when;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Drive one byte for one cycle; called at posedge+1, returns at posedge+1.
    task automatic send(input logic [7:0] b);
        rx_data   = b;
        rx_strobe = 1'b1;
        @(posedge clk);
        #1;
        rx_strobe = 1'b0;
        rx_data   = 8'd0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // The strobe just sampled must yield a write visible in this cycle.
    task automatic expect_wr(input logic [9:0] a, input logic [17:0] d);
        exp_t e;
        e.is_go = 1'b0; e.addr = a; e.data = d; e.when = cyc;
        sb.push_back(e);
    endtask

    task automatic expect_go();
        exp_t e;
        e.is_go = 1'b1; e.addr = '0; e.data = '0; e.when = cyc;
        sb.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_we && go) begin
                checks++;
                errors++;
                $display("FAIL we_go_overlap actual we=1 go=1 required not both");
            end
            if (mem_we || go) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse actual we=%0b go=%0b addr=%h data=%h required none",
                             mem_we, go, mem_addr, mem_wdata);
                end else begin
                    e = sb.pop_front();
                    if ((e.is_go != go) || (e.is_go == mem_we) || e.when != cyc ||
                        (!e.is_go && (mem_addr !== e.addr || mem_wdata !== e.data))) begin
                        errors++;
                        $display("FAIL scoreboard actual go=%0b addr=%h data=%h cyc=%0d required go=%0b addr=%h data=%h cyc=%0d",
                                 go, mem_addr, mem_wdata, cyc, e.is_go, e.addr, e.data, e.when);
                    end else if (e.is_go) begin
                        $display("txn go cyc=%0d", cyc);
                    end else begin
                        $display("txn write addr=%h data=%h cyc=%0d", mem_addr, mem_wdata, cyc);
                    end
                end
            end
        end
    endtask

    task automatic stimulus();
        idle(2);
        rst = 1'b0;
        chk("reset_addr", 32'(mem_addr), 0);
        chk("reset_wdata", 32'(mem_wdata), 0);
        chk("reset_error", 32'(error), 0);
        chk("reset_state", 32'(state_out), 0);

        // Address set, then a data word.
        send("@");
        chk("state_addr", 32'(state_out), 2);
        send_str("10\n");
        send("1");
        chk("state_data", 32'(state_out), 1);
        send_str("234\n");
        expect_wr(10'h010, 18'h01234);
        chk("state_idle", 32'(state_out), 0);

        // Auto-increment and truncation to 18 bits.
        send_str("ABCDE ");
        expect_wr(10'h011, 18'h2BCDE);

        // Address wrap.
        send_str("@3FF\n1\n");
        expect_wr(10'h3FF, 18'h00001);
        send_str("2\n");
        expect_wr(10'h000, 18'h00002);

        // Terminators with no digits do nothing.
        send_str("\n\r  \n");
        idle(2);
        chk("blank_error", 32'(error), 0);
        send_str("9\n");
        expect_wr(10'h001, 18'h00009);

        // Illegal byte sets sticky error, digits are dropped.
        send_str("12");
        chk("error_before", 32'(error), 0);
        send("Z");
        chk("error_after_z", 32'(error), 1);
        send_str("\n5\n");
        expect_wr(10'h002, 18'h00005);
        chk("error_sticky", 32'(error), 1);

        // '@' discards pending data digits.
        send_str("55@2\n6\n");
        expect_wr(10'h002, 18'h00006);

        // Go pulses; digits before 'G' are discarded.
        idle(1);
        send("G");
        expect_go();
        idle(2);
        send_str("3g");
        expect_go();
        send_str("4\n");
        expect_wr(10'h003, 18'h00004);
        send_str("ff\n");
        expect_wr(10'h004, 18'h000FF);
        idle(2);
        chk("hold_addr", 32'(mem_addr), 32'h004);
        chk("hold_wdata", 32'(mem_wdata), 32'h0FF);
        chk("hold_we", 32'(mem_we), 0);

        // Reset mid-word discards pending digits.
        send_str("12");
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("rst_mid_addr", 32'(mem_addr), 0);
        chk("rst_mid_wdata", 32'(mem_wdata), 0);
        chk("rst_mid_error", 32'(error), 0);
        chk("rst_mid_state", 32'(state_out), 0);
        send("\n");
        idle(3);
        send_str("7\n");
        expect_wr(10'h000, 18'h00007);

`ifdef UART_HEX_LOADER_ECHO_EN
        idle(3);
        tx_ready = 1'b0;
        chk("echo_idle", 32'(tx_valid), 0);
        send_str("ab");
        idle(1);
        chk("echo_valid", 32'(tx_valid), 1);
        chk("echo_data", 32'(tx_data), 32'h61);
        tx_ready = 1'b1;
        idle(1);
        chk("echo_clear", 32'(tx_valid), 0);
        chk("echo_keep", 32'(tx_data), 32'h61);
        send_str("@\n");
`endif

        idle(4);
        chk("scoreboard_empty", 32'(sb.size()), 0);
    endtask

    initial begin
        fork
            monitor();
            stimulus();
            begin
                #200000;
                checks++;
                errors++;
                $display("FAIL timeout actual=expired required=done");
            end
        join_any
        disable fork;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
